// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: funct3 codes,
// responder state encoding, request record and access legality check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

  // Misaligned halfword/word or an undefined funct3 for the access direction.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic v_err;
    case (funct3)
      F3_LB:   v_err = 1'b0;
      F3_LH:   v_err = off[0];
      F3_LW:   v_err = |off;
      F3_LBU:  v_err = we;
      F3_LHU:  v_err = we | off[0];
      default: v_err = 1'b1;
    endcase
    return v_err;
  endfunction

endpackage

// File: rtl/dmem_resp_ctrl_if.sv
// Valid/ready request and response bundle between the MEM stage (master)
// and the data-memory responder (slave).
interface dmem_resp_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_stall;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_stall
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_stall
  );
endinterface

// File: rtl/sram_bytelane.sv
// Single-port word array with per-byte write enables and a registered
// read port; both happen on the same enabled edge.
module sram_bytelane #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Read returns the pre-write contents when a store shares the edge.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_resp_ctrl.sv
// Multi-cycle data-memory responder for the RV32I MEM stage: one load or
// store in flight, answered LATENCY wait cycles after acceptance.
module dmem_resp_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_resp_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | ready; a valid request is latched on the next edge
  // WAIT  | request held, r_cnt counts remaining wait cycles down to 0
  // RESP  | one-cycle resp_valid; array was accessed on the edge entering it

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  mem_req_t    r_req, w_req_in, w_req_acc;
  logic        w_latch;
  logic        w_acc_err, w_resp_err;
  logic        w_mem_en, w_mem_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_lane, w_mem_q, w_shift, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused;

  assign w_req_in  = {bus.req_we, bus.req_addr, bus.req_wdata, bus.req_funct3};
  // With LATENCY=0 the array is accessed on the accepting edge, before r_req holds it.
  assign w_req_acc = (r_state == ST_IDLE) ? w_req_in : r_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) r_req <= w_req_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_latch = 1'b1;
          if (LATENCY == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_acc_err = access_err(w_req_acc.we, w_req_acc.funct3, w_req_acc.addr[1:0]);
  assign w_mem_en  = (w_state_nxt == ST_RESP) && (r_state != ST_RESP) && !rst;
  assign w_mem_we  = w_req_acc.we && !w_acc_err;

  always_comb begin
    w_be         = 4'b0000;
    w_wdata_lane = w_req_acc.wdata;
    case (w_req_acc.funct3)
      F3_SB: begin
        w_be         = 4'b0001 << w_req_acc.addr[1:0];
        w_wdata_lane = {4{w_req_acc.wdata[7:0]}};
      end
      F3_SH: begin
        w_be         = w_req_acc.addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_lane = {2{w_req_acc.wdata[15:0]}};
      end
      F3_SW:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  sram_bytelane #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk    (clk),
    .i_en   (w_mem_en),
    .i_we   (w_mem_we),
    .i_be   (w_be),
    .i_addr (w_req_acc.addr[AW+1:2]),
    .i_wdata(w_wdata_lane),
    .o_rdata(w_mem_q)
  );

  // Lane extraction uses the latched request, valid throughout RESP.
  assign w_shift = w_mem_q >> {r_req.addr[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_req.addr[1] ? w_mem_q[31:16] : w_mem_q[15:0];

  always_comb begin
    w_load = '0;
    case (r_req.funct3)
      F3_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      F3_LH:   w_load = {{16{w_half[15]}}, w_half};
      F3_LW:   w_load = w_mem_q;
      F3_LBU:  w_load = {24'h0, w_byte};
      F3_LHU:  w_load = {16'h0, w_half};
      default: w_load = '0;
    endcase
  end

  assign w_resp_err     = access_err(r_req.we, r_req.funct3, r_req.addr[1:0]);
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_err   = (r_state == ST_RESP) && w_resp_err;
  assign bus.resp_rdata = ((r_state == ST_RESP) && !r_req.we && !w_resp_err) ? w_load : '0;
  assign bus.mem_stall  = bus.req_valid && !bus.resp_valid;

  // Address bits above the array wrap point are deliberately ignored.
  assign w_unused = ^{r_req.addr[31:AW+2], w_req_acc.addr[31:AW+2], w_shift[31:8]};
endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Directed bench for dmem_resp_ctrl: two instances (LATENCY 2 and 0) checked
// every cycle against a byte-level memory model plus literal expectations.
module tb_dmem_resp_ctrl;
  localparam int DEPTH   = 1024;
  localparam int LAT_A   = 2;
  localparam int LAT_B   = 0;
  localparam int MAXWAIT = 40;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  dmem_resp_ctrl_if ifa ();
  dmem_resp_ctrl_if ifb ();

  dmem_resp_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa));
  dmem_resp_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          m_busy [2];
  int          m_due  [2];
  logic        m_we   [2];
  logic [2:0]  m_f3   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] mmem [int];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Byte-granular reference: size/sign from funct3, alignment by modulo.
  task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rd);
    int size, off, key;
    logic uns;
    logic [31:0] w, mask;
    uns = f3[2];
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    off = int'(addr[1:0]);
    err = (size == 0) || (uns && (we || size == 4));
    if (size != 0 && (off % size) != 0) err = 1'b1;
    key = d * DEPTH + int'((addr >> 2) % DEPTH);
    rd = 32'h0;
    if (!err) begin
      w = mmem.exists(key) ? mmem[key] : 32'h0;
      if (we) begin
        for (int k = 0; k < size; k++) w[8*(off+k) +: 8] = wdata[8*k +: 8];
        mmem[key] = w;
      end else begin
        rd = w >> (8 * off);
        if (size < 4) begin
          mask = (32'h1 << (8 * size)) - 32'h1;
          rd = rd & mask;
          if (!uns && rd[8*size-1]) rd = rd | ~mask;
        end
      end
    end
  endtask

  task automatic model_step(input int d, input logic rs, input logic vin, input logic we,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic rdy, input logic rv,
                            input logic er, input logic st, input logic [31:0] rd);
    logic e_rv, e_er;
    logic [31:0] e_rd;
    string tg;
    tg = (d == 0) ? "A" : "B";
    e_rv = 1'b0; e_er = 1'b0; e_rd = 32'h0;
    if (rs) m_busy[d] = 1'b0;
    else if (m_busy[d] && cyc == m_due[d]) begin
      e_rv = 1'b1;
      model_access(d, m_we[d], m_f3[d], m_addr[d], m_wdata[d], e_er, e_rd);
    end
    check({tg, ".req_ready"},  32'(rdy), 32'(!m_busy[d]));
    check({tg, ".resp_valid"}, 32'(rv),  32'(e_rv));
    check({tg, ".resp_err"},   32'(er),  32'(e_er));
    check({tg, ".resp_rdata"}, rd, e_rd);
    check({tg, ".mem_stall"},  32'(st),  32'(vin & ~e_rv));
    if (!rs) begin
      if (e_rv) m_busy[d] = 1'b0;
      else if (!m_busy[d] && vin) begin
        m_busy[d]  = 1'b1;
        m_due[d]   = cyc + 1 + ((d == 0) ? LAT_A : LAT_B);
        m_we[d]    = we;
        m_f3[d]    = f3;
        m_addr[d]  = addr;
        m_wdata[d] = wdata;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, rst_a, ifa.req_valid, ifa.req_we, ifa.req_funct3, ifa.req_addr,
               ifa.req_wdata, ifa.req_ready, ifa.resp_valid, ifa.resp_err,
               ifa.mem_stall, ifa.resp_rdata);
    model_step(1, rst_b, ifb.req_valid, ifb.req_we, ifb.req_funct3, ifb.req_addr,
               ifb.req_wdata, ifb.req_ready, ifb.resp_valid, ifb.resp_err,
               ifb.mem_stall, ifb.resp_rdata);
    cyc++;
  end

  task automatic drive(input int d, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      ifa.req_valid = v; ifa.req_we = we; ifa.req_funct3 = f3;
      ifa.req_addr = a;  ifa.req_wdata = wd;
    end else begin
      ifb.req_valid = v; ifb.req_we = we; ifb.req_funct3 = f3;
      ifb.req_addr = a;  ifb.req_wdata = wd;
    end
  endtask

  // Counts cycles from now until resp_valid is seen, then checks literals.
  task automatic wait_resp(input int d, input bit hold, input int exp_n, input logic exp_err,
                           input logic [31:0] exp_rd, input string nm);
    int n;
    logic got_rv, got_err;
    logic [31:0] got_rd;
    n = 0; got_rv = 1'b0; got_err = 1'b0; got_rd = 32'h0;
    while (!got_rv && n < MAXWAIT) begin
      @(negedge clk);
      n++;
      got_rv  = (d == 0) ? ifa.resp_valid : ifb.resp_valid;
      got_err = (d == 0) ? ifa.resp_err   : ifb.resp_err;
      got_rd  = (d == 0) ? ifa.resp_rdata : ifb.resp_rdata;
    end
    if (!got_rv) begin
      total++; bad++;
      $display("FAIL %s.timeout: no resp_valid within %0d cycles", nm, n);
    end else begin
      check({nm, ".cycles"}, n, exp_n);
      check({nm, ".err"},    32'(got_err), 32'(exp_err));
      check({nm, ".rdata"},  got_rd, exp_rd);
    end
    @(posedge clk); #1;
    if (!hold) drive(d, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic do_req(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input int exp_n,
                        input logic exp_err, input logic [31:0] exp_rd, input string nm);
    drive(d, 1'b1, we, f3, a, wd);
    wait_resp(d, hold, exp_n, exp_err, exp_rd, nm);
  endtask

  int seen;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check("rst.ready",  32'(ifa.req_ready), 32'h1);
    check("rst.valid",  32'(ifa.resp_valid), 32'h0);
    check("rst.rdata",  ifa.resp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0;

    // LATENCY=2 basic word path and extension
    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 4, 0, 32'h0,        "sw10");
    do_req(0, 0, 3'b010, 32'h10, 32'h0,        0, 4, 0, 32'hDEADBEEF, "lw10");
    do_req(0, 1, 3'b000, 32'h13, 32'hABCDEF80, 0, 4, 0, 32'h0,        "sb13");
    do_req(0, 0, 3'b000, 32'h13, 32'h0,        0, 4, 0, 32'hFFFFFF80, "lb13");
    do_req(0, 0, 3'b100, 32'h13, 32'h0,        0, 4, 0, 32'h00000080, "lbu13");
    do_req(0, 0, 3'b010, 32'h10, 32'h0,        0, 4, 0, 32'h80ADBEEF, "lw10b");
    do_req(0, 0, 3'b001, 32'h12, 32'h0,        0, 4, 0, 32'hFFFF80AD, "lh12");
    do_req(0, 0, 3'b101, 32'h12, 32'h0,        0, 4, 0, 32'h000080AD, "lhu12");
    do_req(0, 0, 3'b001, 32'h10, 32'h0,        0, 4, 0, 32'hFFFFBEEF, "lh10");
    do_req(0, 0, 3'b000, 32'h11, 32'h0,        0, 4, 0, 32'hFFFFFFBE, "lb11");

    // Misalignment and illegal funct3
    do_req(0, 1, 3'b010, 32'h20, 32'h12345678, 0, 4, 0, 32'h0,        "sw20");
    do_req(0, 1, 3'b001, 32'h21, 32'h0000AAAA, 0, 4, 1, 32'h0,        "sh21_mis");
    do_req(0, 0, 3'b010, 32'h20, 32'h0,        0, 4, 0, 32'h12345678, "lw20");
    do_req(0, 0, 3'b010, 32'h22, 32'h0,        0, 4, 1, 32'h0,        "lw22_mis");
    do_req(0, 0, 3'b011, 32'h20, 32'h0,        0, 4, 1, 32'h0,        "ld_ill011");
    do_req(0, 1, 3'b100, 32'h20, 32'hFFFFFFFF, 0, 4, 1, 32'h0,        "st_ill100");
    do_req(0, 0, 3'b101, 32'h21, 32'h0,        0, 4, 1, 32'h0,        "lhu21_mis");
    do_req(0, 0, 3'b010, 32'h20, 32'h0,        0, 4, 0, 32'h12345678, "lw20b");
    do_req(0, 1, 3'b001, 32'h22, 32'h1111BEEF, 0, 4, 0, 32'h0,        "sh22");
    do_req(0, 0, 3'b010, 32'h20, 32'h0,        0, 4, 0, 32'hBEEF5678, "lw20c");

    // Request fields changed after acceptance must be ignored
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 3'b000, 32'h23, 32'h55);
    wait_resp(0, 0, 3, 0, 32'h80ADBEEF, "lw10_stable");

    // Reset during WAIT aborts a store
    do_req(0, 1, 3'b010, 32'h40, 32'h0, 0, 4, 0, 32'h0, "sw40_zero");
    drive(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    seen = 0;
    @(negedge clk); seen += int'(ifa.resp_valid);
    @(posedge clk); #1;
    rst_a = 1'b1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      seen += int'(ifa.resp_valid);
      check("abort.ready", 32'(ifa.req_ready), 32'h1);
      check("abort.err",   32'(ifa.resp_err),  32'h0);
      check("abort.rdata", ifa.resp_rdata,     32'h0);
    end
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (4) begin @(negedge clk); seen += int'(ifa.resp_valid); end
    check("abort.no_resp", seen, 0);
    @(posedge clk); #1;
    do_req(0, 0, 3'b010, 32'h40, 32'h0, 0, 4, 0, 32'h0, "lw40");

    // Address wrap modulo 4*DEPTH bytes
    do_req(0, 1, 3'b010, 32'h1004, 32'h00000011, 0, 4, 0, 32'h0,        "sw1004");
    do_req(0, 0, 3'b010, 32'h0004, 32'h0,        0, 4, 0, 32'h00000011, "lw0004");

    // LATENCY=0 with back-to-back loads on a held req_valid
    do_req(1, 1, 3'b010, 32'h08, 32'h0000A5A5, 0, 2, 0, 32'h0,        "b.sw08");
    do_req(1, 1, 3'b010, 32'h0C, 32'h5A5A0000, 0, 2, 0, 32'h0,        "b.sw0c");
    do_req(1, 0, 3'b010, 32'h08, 32'h0,        1, 2, 0, 32'h0000A5A5, "b.lw08");
    do_req(1, 0, 3'b010, 32'h0C, 32'h0,        1, 2, 0, 32'h5A5A0000, "b.lw0c");
    do_req(1, 0, 3'b101, 32'h0E, 32'h0,        1, 2, 0, 32'h00005A5A, "b.lhu0e");
    do_req(1, 0, 3'b010, 32'h09, 32'h0,        0, 2, 1, 32'h0,        "b.lw09_mis");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
